wptr_full: RTL
==============

// Module: wptr_full
// PURPOSE
//  - Write-clock-domain end of the async FIFO; counterpart of the read-side pointer/empty logic.
//  - Keeps an (ADDR_W+1)-bit binary write counter, which addresses the buffer.
//  - Keeps a registered Gray-coded write pointer, which is exported to the read clock domain.
//  - Flags full against the read pointer after it is synchronised into this domain.
//  - Also provides a sticky overflow flag and an optional almost-full flag.
// PARAMETERS
//  - ADDR_W     4  buffer address width; DEPTH = 2**ADDR_W; legal range >= 2.
//  - AF_MARGIN  2  almost-full asserts when fill >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.
// PORTS
//  - i_clk        in   1         write clock.
//  - i_rst        in   1         synchronous, active-low reset (0 = reset), sampled on posedge i_clk.
//  - i_inc        in   1         write request.
//  - i_readPtr    in   ADDR_W+1  Gray read pointer, already 2-flop synchronised into i_clk.
//  - i_ovfClr     in   1         clears o_overflow.
//  - o_writePtr   out  ADDR_W+1  registered Gray write pointer, to the read domain.
//  - o_writeAddr  out  ADDR_W    buffer write address = binary counter [ADDR_W-1:0].
//  - o_writeEn    out  1         buffer write strobe = i_inc && !o_full (combinational).
//  - o_full       out  1         FIFO full, registered.
//  - o_almostFull out  1         fill >= DEPTH-AF_MARGIN, registered; tied 0 when the feature is off.
//  - o_overflow   out  1         sticky: a write was attempted while full.
// BEHAVIOUR
//  - Reset, when i_rst==0 at posedge:
//    - binary counter, Gray counter, o_full, o_almostFull and o_overflow all go to 0.
//    - o_writeAddr=0, o_writePtr=0.
//    - Reset overrides every other input, including mid-burst; no write is accepted in that cycle.
//  - Next-state values:
//    - bin_d = bin_q + (i_inc && !o_full), modulo 2**(ADDR_W+1); bit ADDR_W is the wrap bit.
//    - gray_d = (bin_d>>1) ^ bin_d.
//    - o_writePtr = gray_q. Only one bit changes per write, which is a CDC requirement.
//  - Full:
//    - full_d = (gray_d == {~i_readPtr[ADDR_W:ADDR_W-1], i_readPtr[ADDR_W-2:0]}); o_full <= full_d.
//    - o_full asserts on the same edge that accepts the DEPTH-th unread write.
//    - o_full deasserts on the first edge where the synchronised read pointer has advanced.
//    - That is 2-3 read-side pops plus sync latency late. The flag is pessimistic and never optimistic.
//  - Write gating while full:
//    - i_inc while o_full: no counter change, o_writeEn=0, o_overflow <= 1.
//  - o_overflow priority:
//    - i_ovfClr clears o_overflow on the next edge.
//    - If an overflowing i_inc arrives in the same cycle, set wins and o_overflow stays 1.
//  - Wrap: the counter wraps naturally. o_writeAddr returns to 0 after DEPTH-1; the wrap bit toggles.
//  - Simultaneous write and read-pointer advance:
//    - full_d is evaluated on the new values of both pointers.
//    - A write that fills the last slot while the read pointer advances gives full_d=0.
//  - No internal state machine beyond the counters and flags. Latency from i_inc to o_writePtr is 1 cycle.
// CONFIGURATION
//  - Macro WPTR_FULL_ALMOST_FULL_EN.
//  - When defined:
//    - rbin = gray-to-binary(i_readPtr), using an XOR prefix from the MSB down.
//    - fill_d = bin_d - rbin, computed in ADDR_W+1 bits modulo arithmetic.
//    - o_almostFull <= (fill_d >= DEPTH-AF_MARGIN). It is pessimistic in the same way as o_full.
//  - When undefined: no conversion logic is built and o_almostFull is tied to 1'b0. The port stays present.
// TESTING
//  - Reset: hold i_rst=0 for 3 cycles with i_inc=1.
//    -> all outputs 0; then release with i_inc=0 -> outputs unchanged.
//  - Fill: ADDR_W=4, i_readPtr=0, 16 consecutive i_inc.
//    -> o_writeAddr 0..15; o_full=1 after the 16th edge; o_writePtr=5'b11000 (Gray of 16).
//  - Overflow: while full, 1 further i_inc.
//    -> counter held, o_writeEn=0, o_overflow=1.
//    -> Then i_ovfClr with i_inc=1 -> o_overflow stays 1. i_ovfClr alone -> 0.
//  - Drain/wrap: step i_readPtr to Gray(1).
//    -> o_full=0 on the next edge.
//    -> 17 more writes across steps: o_writeAddr wraps 15->0 and the wrap bit toggles.
//    -> o_writePtr changes exactly 1 bit per write (checked by assertion).
//  - Almost full, macro defined, AF_MARGIN=2, i_readPtr=0: 14 writes.
//    -> o_almostFull=1 after the 14th edge.
//    -> Step i_readPtr to Gray(2) -> deasserts on the next edge.
//    -> With the macro undefined: o_almostFull stays 0 throughout.
//  - Mid-operation reset: assert i_rst=0 during a write burst with o_full=1.
//    -> next edge: all outputs 0 and o_writeEn gated.

Source files
------------

// File: rtl/wptr_full.sv
// Write-side pointer and full logic of an async FIFO: binary/Gray write counters, full,
// sticky overflow and an optional almost-full flag (enabled by WPTR_FULL_ALMOST_FULL_EN).
module wptr_full #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic [ADDR_W:0]   i_readPtr,
  input  logic              i_ovfClr,
  output logic [ADDR_W:0]   o_writePtr,
  output logic [ADDR_W-1:0] o_writeAddr,
  output logic              o_writeEn,
  output logic              o_full,
  output logic              o_almostFull,
  output logic              o_overflow
);

  logic [ADDR_W:0] bin_q, bin_d;
  logic [ADDR_W:0] gray_q, gray_d;
  logic [ADDR_W:0] rptr_full;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;

  // A write is never accepted while reset is asserted.
  assign o_writeEn = i_inc && !full_q && i_rst;

  always_comb begin
    bin_d     = bin_q + {{ADDR_W{1'b0}}, o_writeEn};
    gray_d    = (bin_d >> 1) ^ bin_d;
    // Full when the pointers differ only in the two MSBs of their Gray codes.
    rptr_full = {~i_readPtr[ADDR_W:ADDR_W-1], i_readPtr[ADDR_W-2:0]};
    full_d    = (gray_d == rptr_full);
    // Set wins over clear.
    ovf_d     = (i_inc && full_q) ? 1'b1 : (i_ovfClr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef WPTR_FULL_ALMOST_FULL_EN
  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AfThresh = (ADDR_W + 1)'(Depth - AF_MARGIN);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] fill_d;
  logic            af_q, af_d;

  always_comb begin
    rbin[ADDR_W] = i_readPtr[ADDR_W];
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ i_readPtr[i];
    end
    fill_d = bin_d - rbin;
    af_d   = (fill_d >= AfThresh);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign o_almostFull = af_q;
`else
  assign o_almostFull = 1'b0;
`endif

  assign o_writePtr  = gray_q;
  assign o_writeAddr = bin_q[ADDR_W-1:0];
  assign o_full      = full_q;
  assign o_overflow  = ovf_q;

endmodule
